// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the multi-channel interrupt aggregator.
package irq_ctrl_pkg;

    localparam logic IRQ_MODE_EDGE  = 1'b0;
    localparam logic IRQ_MODE_LEVEL = 1'b1;

    localparam int IRQ_ID_W = 5;

    // Saturation value of a pending counter of the given width.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/irq_ctrl_channel.sv
// One interrupt channel: event synchroniser, rise detect, saturating pending
// counter and sticky overflow flag.
module irq_ctrl_channel
    import irq_ctrl_pkg::*;
#(
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             event_i,
    input  logic             mode_i,
    input  logic             enable_i,
    input  logic             global_en_i,
    input  logic             clear_i,
    input  logic             ovf_clr_i,
    output logic             pending_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;
    logic                   rise;
    logic                   inc;
    logic                   dec;
    logic                   cnt_nz;
    logic                   ovf_set;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign cnt_nz   = (cnt_q != '0);
    assign inc      = rise & enable_i & global_en_i & (mode_i == IRQ_MODE_EDGE);
    assign dec      = clear_i & cnt_nz & (mode_i == IRQ_MODE_EDGE);
    assign ovf_set  = inc & ~dec & (cnt_q == CNT_MAX);

    // A simultaneous event and acknowledge cancel; level mode parks the count at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (mode_i == IRQ_MODE_LEVEL) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q      <= '0;
            overflow_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign pending_o = (mode_i == IRQ_MODE_LEVEL) ? (sync_out & enable_i & global_en_i) : cnt_nz;
    assign count_o   = cnt_q;

endmodule

// File: rtl/irq_ctrl_multi.sv
// N-channel interrupt aggregator with registered irq_o.
// Define IRQ_ID_EN to add the registered lowest-pending-channel ID outputs.
module irq_ctrl_multi
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sys_clk_i,
    input  logic                    rstn_i,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic                    global_en_i,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic                    ovf_clr_i,
    output logic [NUM_CH-1:0]       pending_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       overflow_o,
`ifdef IRQ_ID_EN
    output logic [IRQ_ID_W-1:0]     irq_id_o,
    output logic                    irq_id_vld_o,
`endif
    output logic                    irq_o
);

    logic [NUM_CH-1:0] req;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_ctrl_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .sys_clk_i   (sys_clk_i),
            .rstn_i      (rstn_i),
            .event_i     (event_i[i]),
            .mode_i      (mode_i[i]),
            .enable_i    (enable_i[i]),
            .global_en_i (global_en_i),
            .clear_i     (clear_i[i]),
            .ovf_clr_i   (ovf_clr_i),
            .pending_o   (pending_o[i]),
            .count_o     (count_o[i*CNT_W +: CNT_W]),
            .overflow_o  (overflow_o[i])
        );
    end

    // Disabled edge channels keep their count but are masked here.
    assign req = pending_o & enable_i;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (|req) & global_en_i;
        end
    end

`ifdef IRQ_ID_EN
    logic [IRQ_ID_W-1:0] id_d;
    logic                vld_d;

    always_comb begin
        id_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_d = IRQ_ID_W'(i);
            end
        end
        vld_d = (|req) & global_en_i;
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_id_o     <= '0;
            irq_id_vld_o <= 1'b0;
        end else begin
            irq_id_vld_o <= vld_d;
            if (vld_d) begin
                irq_id_o <= id_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Self-checking bench for irq_ctrl_multi: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_irq_ctrl_multi;
    import irq_ctrl_pkg::*;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 5;
    localparam int SYNC   = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [NUM_CH-1:0]       ev, md, en, clr;
    logic                    gen, oclr;
    logic [NUM_CH-1:0]       pending_o, overflow_o;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic                    irq_o;
`ifdef IRQ_ID_EN
    logic [IRQ_ID_W-1:0]     irq_id_o;
    logic                    irq_id_vld_o;
`endif

    irq_ctrl_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .sys_clk_i   (clk),
        .rstn_i      (rstn),
        .event_i     (ev),
        .mode_i      (md),
        .enable_i    (en),
        .global_en_i (gen),
        .clear_i     (clr),
        .ovf_clr_i   (oclr),
        .pending_o   (pending_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
`ifdef IRQ_ID_EN
        .irq_id_o    (irq_id_o),
        .irq_id_vld_o(irq_id_vld_o),
`endif
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Model: events become visible SYNC edges after sampling; pipe[0] is newest sample.
    logic [NUM_CH-1:0] pipe [SYNC+1];
    int                m_cnt [NUM_CH];
    bit [NUM_CH-1:0]   m_ovf;
    bit                m_irq;
    int                m_id;
    bit                m_vld;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] m_pend();
        logic [NUM_CH-1:0] p;
        for (int i = 0; i < NUM_CH; i++)
            p[i] = md[i] ? (pipe[SYNC-1][i] & en[i] & gen) : (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] m_cntvec();
        logic [NUM_CH*CNT_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= SYNC; k++) pipe[k] = '0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_ovf = '0; m_irq = 0; m_id = 0; m_vld = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},   64'(count_o),    64'(m_cntvec()));
        chk({tag, ".pending"}, 64'(pending_o),  64'(m_pend()));
        chk({tag, ".ovf"},     64'(overflow_o), 64'(m_ovf));
        chk({tag, ".irq"},     64'(irq_o),      64'(m_irq));
`ifdef IRQ_ID_EN
        chk({tag, ".id"},      64'(irq_id_o),     64'(m_id));
        chk({tag, ".id_vld"},  64'(irq_id_vld_o), 64'(m_vld));
`endif
    endtask

    // Advance one clock with current inputs, update the model, then check.
    task automatic tick(input string tag);
        logic [NUM_CH-1:0] rise, req;
        bit inc, dec;
        rise = pipe[SYNC-1] & ~pipe[SYNC];
        req  = m_pend() & en;
        m_irq = (|req) && gen;
        m_vld = m_irq;
        if (m_vld) begin
            for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) m_id = i;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (md[i]) begin
                m_cnt[i] = 0;
                if (oclr) m_ovf[i] = 0;
            end else begin
                inc = rise[i] && en[i] && gen;
                dec = clr[i] && (m_cnt[i] != 0);
                if (inc && !dec && m_cnt[i] == MAXC) m_ovf[i] = 1;
                else if (oclr) m_ovf[i] = 0;
                if (inc && !dec && m_cnt[i] < MAXC) m_cnt[i]++;
                else if (dec && !inc) m_cnt[i]--;
            end
        end
        for (int k = SYNC; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = ev;
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m, input string tag);
        ev = ev | m;  tick(tag);
        ev = ev & ~m; tick(tag);
    endtask

    task automatic ack(input logic [NUM_CH-1:0] m, input string tag);
        clr = m; tick(tag); clr = '0;
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0; #1;
        model_reset();
        check_all(tag);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        ev = '0; md = '0; en = '1; clr = '0; gen = 1'b1; oclr = 1'b0; rstn = 1'b1;
        #2;
        do_reset("reset");

        // 1: three pulses counted, three acks drain, irq drops one cycle later
        for (int k = 0; k < 3; k++) pulse(8'h01, "t1_pulse");
        idle(3, "t1_idle");
        chk("t1_count3", 64'(count_o[CNT_W-1:0]), 64'd3);
        chk("t1_irq1",   64'(irq_o), 64'd1);
        for (int k = 0; k < 3; k++) ack(8'h01, "t1_ack");
        chk("t1_count0",  64'(count_o[CNT_W-1:0]), 64'd0);
        chk("t1_irq_lag", 64'(irq_o), 64'd1);
        tick("t1_drop");
        chk("t1_irq0", 64'(irq_o), 64'd0);

        // 2: saturation and sticky overflow
        do_reset("t2_reset");
        for (int k = 0; k < MAXC + 2; k++) pulse(8'h01, "t2_pulse");
        idle(3, "t2_idle");
        chk("t2_sat",  64'(count_o[CNT_W-1:0]), 64'(MAXC));
        chk("t2_ovf1", 64'(overflow_o[0]), 64'd1);
        oclr = 1'b1; tick("t2_oclr"); oclr = 1'b0;
        chk("t2_ovf0",   64'(overflow_o[0]), 64'd0);
        chk("t2_hold31", 64'(count_o[CNT_W-1:0]), 64'(MAXC));

        // 3: rise and ack in the same cycle cancel; ack at zero does not wrap
        do_reset("t3_reset");
        pulse(8'h01, "t3_p"); pulse(8'h01, "t3_p"); idle(3, "t3_idle");
        chk("t3_count2", 64'(count_o[CNT_W-1:0]), 64'd2);
        ev = 8'h01; tick("t3_s1"); tick("t3_s2");
        clr = 8'h01; tick("t3_cancel"); clr = '0; ev = '0;
        chk("t3_cancel2", 64'(count_o[CNT_W-1:0]), 64'd2);
        idle(3, "t3_idle2");
        ack(8'h01, "t3_ack"); ack(8'h01, "t3_ack"); ack(8'h01, "t3_ack0");
        chk("t3_nowrap", 64'(count_o[CNT_W-1:0]), 64'd0);

        // 4: level mode on ch3
        do_reset("t4_reset");
        md = 8'h08; ev = 8'h08; idle(4, "t4_hold");
        chk("t4_pend1", 64'(pending_o[3]), 64'd1);
        chk("t4_irq1",  64'(irq_o), 64'd1);
        ack(8'h08, "t4_ack");
        chk("t4_ackign", 64'(pending_o[3]), 64'd1);
        ev = '0; idle(4, "t4_low");
        chk("t4_pend0", 64'(pending_o[3]), 64'd0);
        chk("t4_irq0",  64'(irq_o), 64'd0);
        md = '0;

        // 5: global disable blocks counting; async reset mid-count
        do_reset("t5_reset");
        gen = 1'b0;
        for (int k = 0; k < 3; k++) pulse(8'h02, "t5_gdis");
        idle(3, "t5_idle");
        chk("t5_nocount", 64'(count_o), 64'd0);
        chk("t5_noirq",   64'(irq_o), 64'd0);
        gen = 1'b1;
        pulse(8'h02, "t5_p"); pulse(8'h02, "t5_p"); idle(3, "t5_idle2");
        chk("t5_count2", 64'(count_o[CNT_W +: CNT_W]), 64'd2);
        do_reset("t5_midrst");

`ifdef IRQ_ID_EN
        // 6: lowest pending enabled channel wins
        pulse(8'h24, "t6_p"); idle(3, "t6_idle");
        chk("t6_id2", 64'(irq_id_o), 64'd2);
        ack(8'h04, "t6_ack2"); tick("t6_t");
        chk("t6_id5", 64'(irq_id_o), 64'd5);
        ack(8'h20, "t6_ack5"); tick("t6_t");
        chk("t6_vld0",  64'(irq_id_vld_o), 64'd0);
        chk("t6_idhold", 64'(irq_id_o), 64'd5);
`endif

        // Random traffic against the model
        do_reset("rnd_reset");
        for (int n = 0; n < 600; n++) begin
            ev   = NUM_CH'($urandom);
            clr  = NUM_CH'($urandom) & NUM_CH'($urandom);
            en   = NUM_CH'($urandom) | NUM_CH'($urandom) | NUM_CH'($urandom);
            gen  = ($urandom_range(0, 7) != 0);
            oclr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) md[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
